mem_access_responder: RTL and testbench



---
 rtl/mem_access_responder_pkg.sv | 46 ++++
 rtl/mem_access_responder_line_array.sv | 17 +
 rtl/mem_access_responder.sv | 88 ++++++++
 tb/tb_mem_access_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_responder_pkg.sv
// mem_access_responder_pkg: cache memory-access protocol types and the serial limits derived from them.
package mem_access_responder_pkg;
  localparam int MSHR_NUM = 2;
  localparam int PHY_ADDR_WIDTH = 32;
  localparam int DCACHE_LINE_BYTE_NUM = 8;
  localparam int DCACHE_LINE_BYTE_NUM_BIT_WIDTH = $clog2(DCACHE_LINE_BYTE_NUM);
  localparam int DCACHE_LINE_WIDTH = DCACHE_LINE_BYTE_NUM * 8;
  localparam int MEM_ACCESS_SERIAL_BIT_SIZE = $clog2(MSHR_NUM) + 1;
  localparam int MEM_WRITE_SERIAL_BIT_SIZE = $clog2(MSHR_NUM);
  localparam int READ_SERIAL_NUM = 2 ** MEM_ACCESS_SERIAL_BIT_SIZE;
  localparam int WRITE_SERIAL_NUM = 2 ** MEM_WRITE_SERIAL_BIT_SIZE;
  localparam int MEM_LINE_INDEX_BIT_WIDTH = 10;
  typedef logic [PHY_ADDR_WIDTH-1:0] PhyAddrPath;
  typedef logic [DCACHE_LINE_WIDTH-1:0] DCacheLinePath;
  typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0] MemAccessSerial;
  typedef logic [MEM_WRITE_SERIAL_BIT_SIZE-1:0] MemWriteSerial;
  typedef logic [MEM_LINE_INDEX_BIT_WIDTH-1:0] MemLineIndexPath;
  typedef struct packed {
    logic valid;
    logic we;
    PhyAddrPath addr;
    DCacheLinePath data;
  } MemAccessReq;
  typedef struct packed {
    logic ack;
    MemAccessSerial serial;
    MemWriteSerial wserial;
  } MemAccessReqAck;
  typedef struct packed {
    logic valid;
    MemAccessSerial serial;
    DCacheLinePath data;
  } MemAccessResult;
  typedef struct packed {
    logic valid;
    MemWriteSerial serial;
  } MemAccessResponse;
  typedef struct packed {
    logic valid;
    logic we;
    MemAccessSerial serial;
    MemWriteSerial wserial;
    MemLineIndexPath line;
    DCacheLinePath data;
  } MemResponderPipeEntry;
endpackage

// File: rtl/mem_access_responder_line_array.sv
// mem_responder_line_array: single-port backing store, synchronous write, combinational read, never reset.
module mem_responder_line_array
  import mem_access_responder_pkg::*;
#(
  parameter int LINE_NUM = 1024
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(LINE_NUM)-1:0] index,
  input  DCacheLinePath               wdata,
  output DCacheLinePath               rdata
);
  DCacheLinePath mem [LINE_NUM];
  always_ff @(posedge clk)
    if (we) mem[index] <= wdata;
  assign rdata = mem[index];
endmodule

// File: rtl/mem_access_responder.sv
// mem_access_responder: fixed-latency main-memory stand-in answering cache MemAccessReq traffic.
module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int MEM_LINE_NUM = 1024
) (
  input  logic             clk,
  input  logic             negResetIn,
  input  MemAccessReq      memAccessReq,
  output MemAccessReqAck   memReqAck,
  output MemAccessResult   memAccessResult,
  output MemAccessResponse memAccessResponse
);
  localparam int IW = $clog2(MEM_LINE_NUM);
  localparam int D = LATENCY > 1 ? LATENCY - 1 : 1;
  localparam int RB = MEM_ACCESS_SERIAL_BIT_SIZE;
  localparam int WB = MEM_WRITE_SERIAL_BIT_SIZE;
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end
  if (MEM_LINE_NUM != 2 ** IW || IW > MEM_LINE_INDEX_BIT_WIDTH) begin : g_bad_lines
    $error("MEM_LINE_NUM must be a power of two within the line index width");
  end
  MemResponderPipeEntry head, tail;
  MemResponderPipeEntry stage [D];
  MemAccessSerial rd_serial;
  MemWriteSerial wr_serial;
  logic [RB:0] rd_out;
  logic [WB:0] wr_out;
  logic rd_acc, wr_acc, rd_done, wr_done, unused_addr;
  DCacheLinePath rdata;
  // Counts saturate at exactly 2**bits, so the top bit alone flags a full window.
  assign memReqAck = '{
    ack: memAccessReq.valid && (memAccessReq.we ? !wr_out[WB] : !rd_out[RB]),
    serial: rd_serial,
    wserial: wr_serial
  };
  assign head = '{
    valid: memReqAck.ack,
    we: memAccessReq.we,
    serial: rd_serial,
    wserial: wr_serial,
    line: MemLineIndexPath'(memAccessReq.addr[DCACHE_LINE_BYTE_NUM_BIT_WIDTH +: IW]),
    data: memAccessReq.data
  };
  assign unused_addr = ^memAccessReq.addr;
  if (LATENCY == 1) begin : g_direct
    assign tail = head;
  end else begin : g_piped
    assign tail = stage[D-1];
  end
  assign rd_acc = memReqAck.ack && !memAccessReq.we;
  assign wr_acc = memReqAck.ack && memAccessReq.we;
  assign rd_done = tail.valid && !tail.we;
  assign wr_done = tail.valid && tail.we;
  mem_responder_line_array #(.LINE_NUM(MEM_LINE_NUM)) u_array (
    .clk(clk),
    .we(wr_done),
    .index(tail.line[IW-1:0]),
    .wdata(tail.data),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge negResetIn)
    if (!negResetIn) begin
      stage <= '{default: '0};
      rd_serial <= '0;
      wr_serial <= '0;
      rd_out <= '0;
      wr_out <= '0;
      memAccessResult <= '0;
      memAccessResponse <= '0;
    end else begin
      stage[0] <= head;
      for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
      rd_serial <= rd_serial + MemAccessSerial'(rd_acc);
      wr_serial <= wr_serial + MemWriteSerial'(wr_acc);
      rd_out <= rd_acc && !rd_done ? rd_out + 1'b1 : !rd_acc && rd_done ? rd_out - 1'b1 : rd_out;
      wr_out <= wr_acc && !wr_done ? wr_out + 1'b1 : !wr_acc && wr_done ? wr_out - 1'b1 : wr_out;
      memAccessResult.valid <= rd_done;
      if (rd_done) begin
        memAccessResult.serial <= tail.serial;
        memAccessResult.data <= rdata;
      end
      memAccessResponse.valid <= wr_done;
      if (wr_done) memAccessResponse.serial <= tail.wserial;
    end
endmodule

// File: tb/tb_mem_access_responder.sv
// tb_mem_access_responder: directed checks of acceptance, latency, serial limits, reset and aliasing.
module tb_mem_access_responder;
  import mem_access_responder_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  MemAccessReq req4, req8;
  MemAccessReqAck ack4, ack8;
  MemAccessResult res4, res8;
  MemAccessResponse rsp4, rsp8;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_access_responder #(.LATENCY(4)) u4 (
    .clk(clk), .negResetIn(rst_n), .memAccessReq(req4),
    .memReqAck(ack4), .memAccessResult(res4), .memAccessResponse(rsp4)
  );
  mem_access_responder #(.LATENCY(8)) u8 (
    .clk(clk), .negResetIn(rst_n), .memAccessReq(req8),
    .memReqAck(ack8), .memAccessResult(res8), .memAccessResponse(rsp8)
  );
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic we, input logic [31:0] a, input logic [63:0] d);
    req4 = '{valid: v, we: we, addr: a, data: d};
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      put(0, 0, 0, 0);
      step;
    end
  endtask
  initial begin
    req4 = '0;
    req8 = '0;
    @(negedge clk);
    check("rst_res4", res4, 0);
    check("rst_rsp4", rsp4, 0);
    check("rst_res8", res8, 0);
    check("rst_ack4", ack4.ack, 0);
    step;
    rst_n = 1;
    step;
    req8 = '{valid: 1'b1, we: 1'b0, addr: 32'h0, data: 64'h0};
    for (int t = 0; t <= 8; t++) begin
      @(negedge clk);
      check($sformatf("t3_ack%0d", t), ack8.ack, t < 4 || t == 8);
      if (t < 4) check($sformatf("t3_ser%0d", t), ack8.serial, t);
      if (t > 3 && t < 8) check($sformatf("t3_resv%0d", t), res8.valid, 0);
      if (t == 8) begin
        check("t3_ser_wrap", ack8.serial, 0);
        check("t3_res_v", res8.valid, 1);
        check("t3_res_s", res8.serial, 0);
      end
      step;
    end
    req8 = '0;
    put(1, 1, 32'h80, 64'h1122334455667788);
    check("t1_wack", ack4.ack, 1);
    check("t1_wser", ack4.wserial, 0);
    step;
    idle(3);
    put(0, 0, 0, 0);
    check("t1_rsp_v", rsp4.valid, 1);
    check("t1_rsp_s", rsp4.serial, 0);
    check("t1_res_v0", res4.valid, 0);
    step;
    put(1, 0, 32'h80, 0);
    check("t1_rack", ack4.ack, 1);
    check("t1_rser", ack4.serial, 0);
    step;
    idle(3);
    put(0, 0, 0, 0);
    check("t1_res_v", res4.valid, 1);
    check("t1_res_s", res4.serial, 0);
    check("t1_res_d", res4.data, 64'h1122334455667788);
    check("t1_rsp_v0", rsp4.valid, 0);
    step;
    put(1, 1, 32'h100, 64'hA5A5);
    check("t2_wser", ack4.wserial, 1);
    step;
    put(1, 0, 32'h100, 0);
    check("t2_rser", ack4.serial, 1);
    step;
    idle(2);
    put(0, 0, 0, 0);
    check("t2_rsp_v", rsp4.valid, 1);
    check("t2_rsp_s", rsp4.serial, 1);
    check("t2_res_v0", res4.valid, 0);
    step;
    put(0, 0, 0, 0);
    check("t2_res_v", res4.valid, 1);
    check("t2_res_d", res4.data, 64'hA5A5);
    check("t2_res_s", res4.serial, 1);
    step;
    put(1, 1, 32'h200, 64'h1);
    check("t4_ack0", ack4.ack, 1);
    check("t4_ws0", ack4.wserial, 0);
    step;
    put(1, 1, 32'h208, 64'h2);
    check("t4_ack1", ack4.ack, 1);
    check("t4_ws1", ack4.wserial, 1);
    step;
    put(1, 1, 32'h210, 64'h3);
    check("t4_ack2", ack4.ack, 0);
    step;
    put(1, 1, 32'h210, 64'h3);
    check("t4_ack3", ack4.ack, 0);
    step;
    put(1, 1, 32'h210, 64'h3);
    check("t4_ack4", ack4.ack, 1);
    check("t4_ws4", ack4.wserial, 0);
    check("t4_rsp_v", rsp4.valid, 1);
    check("t4_rsp_s", rsp4.serial, 0);
    step;
    put(0, 0, 0, 0);
    check("t4_rsp5_s", rsp4.serial, 1);
    step;
    idle(2);
    put(0, 0, 0, 0);
    check("t4_rsp8_v", rsp4.valid, 1);
    check("t4_rsp8_s", rsp4.serial, 0);
    step;
    for (int i = 0; i < 10; i++) begin
      put(0, i[0], 32'h80, 64'hFFFF);
      check($sformatf("idle_ack%0d", i), ack4.ack, 0);
      check($sformatf("idle_res%0d", i), res4.valid, 0);
      check($sformatf("idle_rsp%0d", i), rsp4.valid, 0);
      step;
    end
    check("hold_res_d", res4.data, 64'hA5A5);
    check("hold_res_s", res4.serial, 1);
    put(1, 1, 32'h80, 64'hDEADBEEFCAFEF00D);
    check("t6_wser", ack4.wserial, 1);
    step;
    put(1, 0, 32'h2080, 0);
    check("t6_rser", ack4.serial, 2);
    step;
    idle(3);
    put(0, 0, 0, 0);
    check("t6_res_v", res4.valid, 1);
    check("t6_res_d", res4.data, 64'hDEADBEEFCAFEF00D);
    step;
    put(1, 0, 32'h80, 0);
    check("t5_rser", ack4.serial, 3);
    step;
    idle(1);
    rst_n = 0;
    put(0, 0, 0, 0);
    check("t5_rst_res", res4, 0);
    check("t5_rst_rsp", rsp4, 0);
    step;
    rst_n = 1;
    idle(1);
    put(0, 0, 0, 0);
    check("t5_no_res", res4.valid, 0);
    step;
    put(1, 0, 32'h80, 0);
    check("t5_rack", ack4.ack, 1);
    check("t5_rser0", ack4.serial, 0);
    step;
    idle(3);
    put(0, 0, 0, 0);
    check("t5_res_v", res4.valid, 1);
    check("t5_res_s", res4.serial, 0);
    check("t5_res_d", res4.data, 64'hDEADBEEFCAFEF00D);
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
